// File: rtl/uart_receiver.sv
// UART receive stage: 8N1+ framing, oversampled, with framing-error and idle-gap detection.
// Optional UART_RX_GLITCH_FILTER_EN: 2-of-3 majority filter on the synchronized line, sampled on ticks.
module uart_receiver #(
  parameter int unsigned ClkFrequency = 100000000,
  parameter int unsigned Baud         = 115200,
  parameter int unsigned Oversampling = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       frame_error,
  output logic       RxD_idle,
  output logic       RxD_endofpacket
);

  localparam int unsigned ACC_W = 16;
  localparam logic [63:0] INC_L =
    (((64'(Baud) * 64'(Oversampling)) << ACC_W) + 64'(ClkFrequency / 2)) / 64'(ClkFrequency);
  localparam logic [ACC_W:0] INC = INC_L[ACC_W:0];

  localparam int unsigned OS_W  = $clog2(Oversampling);
  localparam logic [OS_W-1:0] HALF = OS_W'(Oversampling / 2 - 1);
  localparam logic [OS_W-1:0] FULL = OS_W'(Oversampling - 1);

  localparam int unsigned GAP_W = $clog2(10 * Oversampling + 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(10 * Oversampling);
  localparam logic [GAP_W-1:0] GAP_PREV = GAP_W'(10 * Oversampling - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [ACC_W:0]   r_acc;
  logic             w_tick;
  logic [1:0]       r_sync;
  logic             w_line;
  logic [2:0]       r_state;
  logic [OS_W-1:0]  r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [GAP_W-1:0] r_gap;
  logic             r_got;

  // Carry out of the fractional accumulator is the oversample tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_acc <= '0;
    else       r_acc <= {1'b0, r_acc[ACC_W-1:0]} + INC;
  end
  assign w_tick = r_acc[ACC_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= '1;
    else       r_sync <= {r_sync[0], RxD};
  end

`ifdef UART_RX_GLITCH_FILTER_EN
  logic [2:0] r_filt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_filt <= '1;
    else if (w_tick) r_filt <= {r_filt[1:0], r_sync[1]};
  end
  assign w_line = (r_filt[0] & r_filt[1]) | (r_filt[1] & r_filt[2]) | (r_filt[0] & r_filt[2]);
`else
  assign w_line = r_sync[1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_bit          <= '0;
      r_shift        <= '0;
      RxD_data       <= '0;
      RxD_data_ready <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      RxD_data_ready <= 1'b0;
      frame_error    <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_IDLE: if (!w_line) begin
            r_state <= S_START;
            r_cnt   <= HALF;
          end
          S_START: begin
            if (r_cnt != '0) r_cnt <= r_cnt - OS_W'(1);
            else if (!w_line) begin
              r_state <= S_DATA;
              r_cnt   <= FULL;
              r_bit   <= '0;
            end else r_state <= S_IDLE;
          end
          S_DATA: begin
            if (r_cnt != '0) r_cnt <= r_cnt - OS_W'(1);
            else begin
              r_shift <= {w_line, r_shift[7:1]};
              r_cnt   <= FULL;
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) r_state <= S_STOP;
            end
          end
          S_STOP: begin
            if (r_cnt != '0) r_cnt <= r_cnt - OS_W'(1);
            else if (w_line) begin
              RxD_data       <= r_shift;
              RxD_data_ready <= 1'b1;
              r_state        <= S_IDLE;
            end else begin
              frame_error <= 1'b1;
              r_state     <= S_WAIT;
            end
          end
          S_WAIT:  if (w_line) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // End-of-packet is registered on the same edge the gap counter saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gap           <= GAP_MAX;
      r_got           <= 1'b0;
      RxD_endofpacket <= 1'b0;
    end else begin
      RxD_endofpacket <= 1'b0;
      if (r_state != S_IDLE || !w_line) r_gap <= '0;
      else if (w_tick && r_gap != GAP_MAX) begin
        r_gap <= r_gap + GAP_W'(1);
        if (r_gap == GAP_PREV && r_got) RxD_endofpacket <= 1'b1;
      end
      if (RxD_data_ready)       r_got <= 1'b1;
      else if (RxD_endofpacket) r_got <= 1'b0;
    end
  end

  assign RxD_idle = (r_gap == GAP_MAX);

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized scoreboard bench for uart_receiver; a fast baud keeps the run short.
module tb_uart_receiver;
  localparam int unsigned CLK_HZ = 100_000_000;
  localparam int unsigned BAUD   = 1_000_000;
  localparam int unsigned OS     = 8;
  localparam int BIT = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       RxD;
  logic [7:0] RxD_data;
  logic       RxD_data_ready, frame_error, RxD_idle, RxD_endofpacket;

  always #5 clk = ~clk;

  uart_receiver #(.ClkFrequency(CLK_HZ), .Baud(BAUD), .Oversampling(OS)) dut (
    .clk(clk), .reset(reset), .RxD(RxD), .RxD_data(RxD_data),
    .RxD_data_ready(RxD_data_ready), .frame_error(frame_error),
    .RxD_idle(RxD_idle), .RxD_endofpacket(RxD_endofpacket)
  );

  // kind: 0 = good byte, 1 = framing error (val = data that must be held), 2 = end of packet
  typedef struct { int kind; logic [7:0] val; } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] m_last = 8'h00;
  bit m_got = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] d);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: kind %0d data 0x%0h, expected no event", kind, d);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      if (kind != 2 && e.kind == kind) check(kind == 0 ? "rx_data" : "fe_data_hold", d, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (RxD_data_ready) expect_ev(0, RxD_data);
      if (frame_error)    expect_ev(1, RxD_data);
      if (RxD_endofpacket) begin
        expect_ev(2, 8'h00);
        check("eop_with_idle", RxD_idle, 1);
      end
    end
  end

  task automatic push(input int kind, input logic [7:0] v);
    exp_t e;
    e.kind = kind;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic drive(input logic v, input int clks);
    RxD = v;
    repeat (clks) @(posedge clk);
  endtask

  task automatic frame(input logic [7:0] b, input int stop_clks, input logic stop_val);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(b[i], BIT);
    drive(stop_val, stop_clks);
  endtask

  task automatic send(input logic [7:0] b, input int nstop);
    push(0, b);
    m_last = b;
    m_got  = 1'b1;
    frame(b, nstop * BIT, 1'b1);
  endtask

  // Gaps are either short (<=3 bits) or long (>=12 bits) so the end-of-packet outcome is unambiguous.
  task automatic idle_bits(input int n);
    if (n >= 12 && m_got) begin
      push(2, 8'h00);
      m_got = 1'b0;
    end
    drive(1'b1, n * BIT);
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    check({tag, "_data"},  RxD_data, 0);
    check({tag, "_ready"}, RxD_data_ready, 0);
    check({tag, "_fe"},    frame_error, 0);
    check({tag, "_eop"},   RxD_endofpacket, 0);
    check({tag, "_idle"},  RxD_idle, 1);
  endtask

  initial begin
    logic [7:0] c3;
    int g;
    reset = 1'b1;
    RxD   = 1'b1;
    repeat (5) @(posedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    idle_bits(12);
    @(negedge clk);
    check("idle_after_reset", RxD_idle, 1);

    send(8'h55, 1);
    idle_bits(12);

    send(8'hA5, 1);
    send(8'h3C, 1);
    idle_bits(12);

    drive(1'b0, 23);
    idle_bits(12);
    @(negedge clk);
    check("idle_after_false_start", RxD_idle, 1);

`ifdef UART_RX_GLITCH_FILTER_EN
    push(0, 8'hFF);
    m_last = 8'hFF;
    m_got  = 1'b1;
    drive(1'b0, BIT);
    for (int i = 0; i < 3; i++) drive(1'b1, BIT);
    drive(1'b1, 45);
    drive(1'b0, 10);
    drive(1'b1, 45);
    for (int i = 4; i < 8; i++) drive(1'b1, BIT);
    drive(1'b1, BIT);
    idle_bits(12);
`endif

    push(1, m_last);
    frame(8'hFF, 3 * BIT, 1'b0);
    drive(1'b1, 2 * BIT);
    send(8'h12, 1);
    idle_bits(12);

    c3 = 8'hC3;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(c3[i], BIT);
    drive(c3[4], BIT / 2);
    @(negedge clk);
    reset = 1'b1;
    RxD   = 1'b1;
    m_got = 1'b0;
    check_reset_values("midbyte_reset");
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 2 * BIT);
    send(8'h7E, 1);
    idle_bits(12);

    send(8'h01, 1);
    push(2, 8'h00);
    m_got = 1'b0;
    drive(1'b1, 8 * BIT);
    @(negedge clk);
    check("idle_low_in_gap", RxD_idle, 0);
    drive(1'b1, 4 * BIT);
    @(negedge clk);
    check("idle_high_after_gap", RxD_idle, 1);
    idle_bits(12);

    for (int k = 0; k < 16; k++) begin
      send(8'($urandom_range(0, 255)), int'($urandom_range(1, 2)));
      g = int'($urandom_range(0, 3));
      if (g == 3) idle_bits(12);
      else        idle_bits(g);
    end
    idle_bits(12);

    repeat (BIT) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage: the downstream consumer of the transmitter's serial TxD line (8 data bits, LSB first, no parity, 1+ stop bits). It oversamples the asynchronous RxD input, recovers each byte, and presents it on a parallel bus with a one-cycle valid strobe. It also flags framing errors and detects inter-packet idle gaps. It sits between the board RxD pin and the byte consumer (FIFO, command parser, loopback to the transmitter).

## Interface
- ClkFrequency, 100000000: clk frequency in Hz.
- Baud, 115200: line bit rate.
- Oversampling, 8: samples per bit; must be a power of 2, ≥4.
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- RxD  input  1  asynchronous serial line; idle high.
- RxD_data  output  8  last correctly framed byte; held until the next good byte.
- RxD_data_ready  output  1  one-clk pulse when RxD_data updates.
- frame_error  output  1  one-clk pulse when the stop bit samples low.
- RxD_idle  output  1  high while the line has been high ≥10 bit times.
- RxD_endofpacket  output  1  one-clk pulse when RxD_idle rises after ≥1 byte was received.

## Operation
- **Oversample tick:**
  - Free-running phase accumulator produces a 1-clk tick at Baud×Oversampling; rate error <1%.
  - The accumulator is not gated by state and is cleared by reset.
- **Input path:** 2-flop synchronizer on RxD, reset to 1. Optional filter per Configuration. The result is the "line" signal.
- **FSM states:** IDLE, START, DATA (bit index 0..7), STOP, WAIT_HIGH. An oversample counter (log2(Oversampling) bits) times each bit.
- **IDLE:** on a tick with line=0, go to START and load the counter for a half bit.
- **START:** after Oversampling/2 ticks, re-sample the line.
  - Line=0: go to DATA, bit 0.
  - Line=1: false start; return to IDLE with no output.
- **DATA:** every Oversampling ticks (mid-bit), shift the line into bit[7] of the shift register (right shift, LSB first). After bit 7, go to STOP.
- **STOP:** after Oversampling ticks, sample the line.
  - Line=1: RxD_data ← shift register, pulse RxD_data_ready; go to IDLE.
  - Line=0: pulse frame_error, RxD_data unchanged; go to WAIT_HIGH.
- **WAIT_HIGH:** stay until a tick with line=1, then go to IDLE. A held-low break line yields exactly one frame_error.
- **Gap detector:**
  - Counter of ticks with line=1 while in IDLE; cleared by any line=0 or any non-IDLE state.
  - Saturates at 10×Oversampling; RxD_idle = saturated.
  - A got_byte flag is set by RxD_data_ready and cleared when RxD_endofpacket fires.
- **Reset values:**
  - RxD_data=0x00, RxD_data_ready=0, frame_error=0, RxD_endofpacket=0.
  - RxD_idle=1 (gap counter resets saturated); got_byte=0; FSM=IDLE.
- **Reset mid-byte:** the partial byte is discarded with no strobe.

## Timing
- Start edge detection is quantised to one tick: up to 1/Oversampling bit jitter.
- RxD_data_ready / frame_error assert on the clk after the stop-bit sample tick (mid stop bit, ~9.5 bit times after the falling start edge, plus synchronizer and filter delay).
- Strobes are exactly 1 clk wide; RxD_data is valid from that cycle until the next strobe.
- Back-to-back frames with one stop bit must be received: the FSM is back in IDLE by mid stop bit.
- RxD_endofpacket is coincident with the RxD_idle rising edge. It never fires out of reset, or twice for one gap.
- Simultaneous reset and any event: reset wins.

## Configuration
- Macro: UART_RX_GLITCH_FILTER_EN.
- Defined:
  - Line = 2-of-3 majority of the last three synchronizer outputs, sampled on ticks.
  - Adds 1–2 ticks of latency.
  - Single-tick glitches are rejected everywhere, including within data bits.
- Undefined: line = synchronizer output directly; the only glitch rejection is the START re-check.

## Test plan
Defaults apply: 100 MHz, 115200 baud, Oversampling 8; bit ≈ 868 clks.
- Drive 0x55 framed with 1 stop bit -> single RxD_data_ready pulse, RxD_data=0x55, frame_error stays 0.
- Drive 0xA5 then 0x3C back-to-back with 1 stop bit -> two ready pulses in order, data 0xA5 then 0x3C.
- Drive a 200-clk low pulse on an idle line -> no ready and no frame_error; state returns to IDLE. With the macro defined, a 1-tick low glitch inside bit 3 of 0xFF still yields 0xFF.
- Drive 0xFF with the stop bit low for 3 bit times, then high -> one frame_error pulse, no ready, RxD_data keeps its prior value. The next 0x12 is received correctly.
- Assert reset at bit 4 of 0xC3, release, then drive 0x7E -> outputs at reset values during reset, no strobe for 0xC3, RxD_data=0x7E afterward.
- Drive 0x01, then hold the line high 12 bit times -> RxD_idle rises ~10 bit times after the stop bit with a single RxD_endofpacket pulse. Also check: no pulse after reset alone, and none on a second idle gap with no byte received.
